// File: rtl/constants_pkg.sv
// Shared fetch constants and the {pc, insn} packet type.
package constants_pkg;
  localparam int          FETCH_AWIDTH   = 32;
  localparam int          FETCH_DWIDTH   = 32;
  localparam logic [31:0] FETCH_BASEADDR = 32'h0100_0000;
  localparam int          INSN_BYTES     = 4;

  typedef struct packed {
    logic [FETCH_AWIDTH-1:0] pc;
    logic [FETCH_DWIDTH-1:0] insn;
  } fetch_pkt_t;
endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer catching a response that arrives while the output slot is stalled.
module fetch_skid
  import constants_pkg::*;
#(
  parameter type pkt_t = fetch_pkt_t
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic wr_en,
  input  pkt_t wr_pkt,
  input  logic rd_en,
  output logic full,
  output pkt_t rd_pkt
);
  pkt_t buf_q;
  logic full_q;

  always_ff @(posedge clk) begin
    if (reset || flush)  full_q <= 1'b0;
    else if (wr_en)      full_q <= 1'b1;
    else if (rd_en)      full_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)       buf_q <= '0;
    else if (wr_en)  buf_q <= wr_pkt;
  end

  assign full   = full_q;
  assign rd_pkt = buf_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, 1-cycle imem, skid-buffered valid/ready output.
// Optional FETCH_PERF_CNT_EN adds handshake and stall counters.
module fetch_stage
  import constants_pkg::*;
#(
  parameter int               DWIDTH   = FETCH_DWIDTH,
  parameter int               AWIDTH   = FETCH_AWIDTH,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(FETCH_BASEADDR)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  input  logic              redirect_valid_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetched_cnt_o,
  output logic [31:0]       stall_cnt_o
`endif
);
  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } pkt_t;

  logic [AWIDTH-1:0] pc_q, pend_pc_q;
  logic              pend_q, valid_q;
  pkt_t              out_q, resp_pkt, skid_pkt;
  logic              issue, hs, stall, load_resp, skid_full, skid_wr, skid_rd;

  assign stall     = valid_q && !ready_i;
  assign hs        = valid_q && ready_i;
  assign issue     = !reset && !redirect_valid_i && !skid_full && !stall;
  assign resp_pkt  = '{pc: pend_pc_q, insn: imem_rdata_i};
  // A response goes straight to the output only if nothing older sits in the skid.
  assign load_resp = pend_q && !stall && !skid_full;
  assign skid_wr   = pend_q && !load_resp && !redirect_valid_i;
  assign skid_rd   = hs && skid_full && !redirect_valid_i;

  fetch_skid #(.pkt_t(pkt_t)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .flush  (redirect_valid_i),
    .wr_en  (skid_wr),
    .wr_pkt (resp_pkt),
    .rd_en  (skid_rd),
    .full   (skid_full),
    .rd_pkt (skid_pkt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= BASEADDR;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      valid_q   <= 1'b0;
      out_q     <= '0;
    end else if (redirect_valid_i) begin
      pc_q    <= redirect_pc_i & ~AWIDTH'(INSN_BYTES - 1);
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pend_q <= issue;
      if (issue) begin
        pend_pc_q <= pc_q;
        pc_q      <= pc_q + AWIDTH'(INSN_BYTES);
      end
      if (hs && skid_full) begin
        out_q   <= skid_pkt;
        valid_q <= 1'b1;
      end else if (load_resp) begin
        out_q   <= resp_pkt;
        valid_q <= 1'b1;
      end else if (hs) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q;
  assign valid_o     = valid_q;
  assign pc_o        = out_q.pc;
  assign insn_o      = out_q.insn;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, stall_q;

  // Counters only clear on reset; redirects do not touch them.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      if (hs)    fetched_q <= fetched_q + 32'd1;
      if (stall) stall_q   <= stall_q + 32'd1;
    end
  end

  assign fetched_cnt_o = fetched_q;
  assign stall_cnt_o   = stall_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a PC-sequence reference model.
module tb_fetch_stage;
  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        ready_i = 1'b1;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] insn_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_cnt_o, stall_cnt_o;
  logic [31:0] m_fetch = '0, m_stall = '0;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_rdata_i     (imem_rdata_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .ready_i          (ready_i),
    .valid_o          (valid_o),
    .pc_o             (pc_o),
    .insn_o           (insn_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetched_cnt_o    (fetched_cnt_o),
    .stall_cnt_o      (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'h13 + ((a - BASE) >> 2);
  endfunction

  // Synchronous memory; garbage when not read so stale data is visible.
  always @(posedge clk)
    imem_rdata_i <= imem_req_o ? memw(imem_addr_o) : $urandom;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference: expected next delivered PC, cycles since last flush, held packet under stall.
  logic [31:0] exp_pc = BASE;
  int          since = 1000;
  logic        prev_rst = 1'b0, stall_prev = 1'b0;
  logic [31:0] held_pc, held_insn;

  always @(negedge clk) begin
    if (since < 1000) since++;
    if (prev_rst) begin
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_pc", pc_o, 0);
      chk("rst_insn", insn_o, 0);
    end
    if (since == 1 || since == 2) chk("flush_valid", 32'(valid_o), 0);
    if (since == 3) chk("first_pkt_lat", 32'(valid_o), 1);
    if (since == 1 && !reset && !redirect_valid_i) begin
      chk("issue_req", 32'(imem_req_o), 1);
      chk("issue_addr", imem_addr_o, exp_pc);
    end
    if (stall_prev) begin
      chk("hold_valid", 32'(valid_o), 1);
      chk("hold_pc", pc_o, held_pc);
      chk("hold_insn", insn_o, held_insn);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("fetched_cnt", fetched_cnt_o, m_fetch);
    chk("stall_cnt", stall_cnt_o, m_stall);
`endif
    prev_rst   = 1'b0;
    stall_prev = 1'b0;
    if (reset) begin
      chk("rst_req", 32'(imem_req_o), 0);
      exp_pc   = BASE;
      since    = 0;
      prev_rst = 1'b1;
`ifdef FETCH_PERF_CNT_EN
      m_fetch = '0;
      m_stall = '0;
`endif
    end else begin
      if (valid_o && !ready_i) begin
        chk("stall_req", 32'(imem_req_o), 0);
        if (!redirect_valid_i) begin
          stall_prev = 1'b1;
          held_pc    = pc_o;
          held_insn  = insn_o;
        end
`ifdef FETCH_PERF_CNT_EN
        m_stall++;
`endif
      end
      if (valid_o && ready_i) begin
        chk("pkt_pc", pc_o, exp_pc);
        chk("pkt_insn", insn_o, memw(exp_pc));
        exp_pc = exp_pc + 32'd4;
`ifdef FETCH_PERF_CNT_EN
        m_fetch++;
`endif
      end
      if (redirect_valid_i) begin
        chk("redir_req", 32'(imem_req_o), 0);
        exp_pc = redirect_pc_i & ~32'd3;
        since  = 0;
      end
    end
  end

  task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    reset            = r;
    ready_i          = rdy;
    redirect_valid_i = rv;
    redirect_pc_i    = rpc;
  endtask

  initial begin
    drive(1, 1, 0, 0);
    drive(0, 1, 0, 0);
    repeat (12) drive(0, 1, 0, 0);
    // stall for 3 cycles, then release
    repeat (3) drive(0, 0, 0, 0);
    repeat (6) drive(0, 1, 0, 0);
    // redirect in the middle of a stall
    repeat (2) drive(0, 0, 0, 0);
    drive(0, 0, 1, 32'h0100_0042);
    repeat (8) drive(0, 1, 0, 0);
    // wrap-around target
    drive(0, 1, 1, 32'hFFFF_FFFC);
    repeat (8) drive(0, 1, 0, 0);
    // reset with the skid full
    repeat (3) drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    repeat (10) drive(0, 1, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, rv;
      logic [31:0] t;
      r  = ($urandom % 150) == 0;
      rv = ($urandom % 30) == 0;
      t  = ($urandom % 4 == 0) ? 32'hFFFF_FFF0 + ($urandom % 16) : BASE + ($urandom % 256);
      drive(r, ($urandom % 4) != 0, rv, t);
    end
    repeat (6) drive(0, 1, 0, 0);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
